// File: rtl/gb_csr_fifo_responder.sv
// Ghostbus leaf responder: CSR bank, RAM window and a pop-on-read FIFO window.
// Address offsets are taken relative to BASE. The block spans [0, 2*2**RAM_AW):
//   0..CSR_N-1  CSR R/W
//   8           STATUS RO, {count, full, empty} in the LSBs
//   9           FIFO_DATA RO, a read pops one word
//   10          ERR_COUNT RO, any write clears it
//   2**RAM_AW.. RAM R/W
// Ports:
//   gb_clk, gb_rst          clock and synchronous active-high reset
//   gb_addr, gb_wdata       access address and write data
//   gb_wen, gb_rstb         one-cycle write and read strobes
//   gb_rdata                registered read data, one cycle after gb_rstb
//   csr_out                 flattened CSR contents, CSR k at [k*GB_DW +: GB_DW]
//   fifo_in_data/valid      fabric push side
//   fifo_in_ready           high while the FIFO is not full
module gb_csr_fifo_responder #(
  parameter int unsigned      GB_AW    = 24,
  parameter int unsigned      GB_DW    = 32,
  parameter int unsigned      BASE     = 0,
  parameter int unsigned      CSR_N    = 4,
  parameter logic [GB_DW-1:0] CSR_INIT = 32'h00000010,
  parameter int unsigned      RAM_AW   = 4,
  parameter logic [GB_DW-1:0] RAM_INIT = 32'h00000080,
  parameter int unsigned      FIFO_AW  = 3
) (
  input  logic                   gb_clk,
  input  logic                   gb_rst,
  input  logic [GB_AW-1:0]       gb_addr,
  input  logic [GB_DW-1:0]       gb_wdata,
  input  logic                   gb_wen,
  input  logic                   gb_rstb,
  output logic [GB_DW-1:0]       gb_rdata,
  output logic [CSR_N*GB_DW-1:0] csr_out,
  input  logic [GB_DW-1:0]       fifo_in_data,
  input  logic                   fifo_in_valid,
  output logic                   fifo_in_ready
);

  localparam int unsigned RAM_DEPTH  = 1 << RAM_AW;
  localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W      = FIFO_AW + 1;
  localparam int unsigned CSR_IW     = (CSR_N > 1) ? $clog2(CSR_N) : 1;
  localparam int unsigned ERR_W      = 16;

  // Power-up image of the RAM; reset never reloads it.
  function automatic logic [RAM_DEPTH-1:0][GB_DW-1:0] ram_init_f();
    logic [RAM_DEPTH-1:0][GB_DW-1:0] v;
    for (int unsigned i = 0; i < RAM_DEPTH; i++) v[i] = RAM_INIT + GB_DW'(i);
    return v;
  endfunction

  logic [CSR_N-1:0][GB_DW-1:0]     csr_q;
  logic [RAM_DEPTH-1:0][GB_DW-1:0] ram_q = ram_init_f();
  logic [GB_DW-1:0]                fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]                count_q;
  logic [ERR_W-1:0]                err_q;

  // Address decode
  logic [GB_AW-1:0]  offset;
  logic              in_block, is_csr, is_status, is_fifo, is_err, is_ram, unmapped;
  logic [CSR_IW-1:0] csr_idx;
  logic [RAM_AW-1:0] ram_idx;

  assign offset    = gb_addr - GB_AW'(BASE);
  assign in_block  = offset < GB_AW'(2 * RAM_DEPTH);
  assign is_csr    = offset < GB_AW'(CSR_N);
  assign is_status = offset == GB_AW'(8);
  assign is_fifo   = offset == GB_AW'(9);
  assign is_err    = offset == GB_AW'(10);
  assign is_ram    = in_block && (offset >= GB_AW'(RAM_DEPTH));
  assign unmapped  = in_block && !(is_csr || is_status || is_fifo || is_err || is_ram);
  assign csr_idx   = offset[CSR_IW-1:0];
  assign ram_idx   = offset[RAM_AW-1:0];

  // FIFO flags come straight from the registered count
  logic full, empty, push, pop;
  assign full          = count_q == CNT_W'(FIFO_DEPTH);
  assign empty         = count_q == '0;
  assign fifo_in_ready = !full;
  assign push          = fifo_in_valid && !full;
  assign pop           = gb_rstb && is_fifo && !empty;

  // Read mux; values are pre-edge, so a same-cycle write is not visible
  logic [GB_DW-1:0] rd_val;
  always_comb begin
    rd_val = '0;
    if (is_csr)         rd_val = csr_q[csr_idx];
    else if (is_status) rd_val = GB_DW'({count_q, full, empty});
    else if (is_fifo)   rd_val = empty ? '0 : fifo_mem[rd_ptr_q];
    else if (is_err)    rd_val = GB_DW'(err_q);
    else if (is_ram)    rd_val = ram_q[ram_idx];
  end

  // Error events: one read-side and one write-side source per cycle, saturating
  logic           rd_err, wr_err, err_clr;
  logic [1:0]     err_inc;
  logic [ERR_W:0] err_sum;
  logic [ERR_W-1:0] err_next;
  assign rd_err   = gb_rstb && (unmapped || (is_fifo && empty));
  assign wr_err   = gb_wen && unmapped;
  assign err_clr  = gb_wen && is_err;
  assign err_inc  = 2'(rd_err) + 2'(wr_err);
  assign err_sum  = {1'b0, err_q} + (ERR_W+1)'(err_inc);
  assign err_next = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];

  // Control state: read data, CSRs, FIFO pointers, error counter
  always_ff @(posedge gb_clk) begin
    if (gb_rst) begin
      gb_rdata <= '0;
      for (int unsigned k = 0; k < CSR_N; k++) csr_q[k] <= CSR_INIT + GB_DW'(k);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      // Reads outside the block leave gb_rdata untouched
      if (gb_rstb && in_block) gb_rdata <= rd_val;
      if (gb_wen && is_csr)    csr_q[csr_idx] <= gb_wdata;
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      err_q <= err_clr ? '0 : err_next;
    end
  end

  // FIFO storage needs no reset; stale words are unreachable once pointers clear
  always_ff @(posedge gb_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= fifo_in_data;
  end

  // RAM keeps its contents across reset
  always_ff @(posedge gb_clk) begin
    if (!gb_rst && gb_wen && is_ram) ram_q[ram_idx] <= gb_wdata;
  end

  assign csr_out = csr_q;

endmodule
